vec_elem_sequencer: RTL and testbench
=====================================

Name: vec_elem_sequencer

Overview:
- Downstream consumer of the vector CSR register file's configuration outputs: vec_length, start_element, sew, vlmul, vlmax, tail_agnostic and mask_agnostic.
- For each vector instruction it accepts, it walks the active element range [vstart, min(vl, vlmax)) in datapath-width beats.
- Each beat carries the first element index, the register offset within the LMUL group, and per-element enable and tail masks.
- Feeds the lane/execute stage through a valid/ready handshake and returns a one-cycle done pulse to the control unit.

Parameters:
- XLEN, 32, scalar/CSR width.
- VLEN, 512, bits per vector register.
- DLEN, 128, datapath bits per beat; max elements per beat NE = DLEN/8 = 16.

Ports:
- clk  in  1  clock
- n_rst  in  1  synchronous active-low reset
- cfg_valid  in  1  new instruction to sequence
- cfg_ready  out  1  sequencer can accept a config
- vec_length  in  XLEN  vl from CSR regfile
- start_element  in  XLEN  vstart from CSR regfile
- sew  in  7  decoded SEW (8/16/32/64)
- vlmul  in  5  decoded LMUL (1/2/4/8)
- vlmax  in  10  VLMAX from CSR regfile
- tail_agnostic  in  1  vta
- mask_agnostic  in  1  vma
- flush  in  1  abort the current instruction
- beat_valid  out  1  beat outputs valid
- beat_ready  in  1  downstream accepts beat
- beat_elem_idx  out  10  index of first element in beat
- beat_reg_off  out  3  register offset within group
- beat_elem_en  out  NE  active-element mask (bit k = element idx+k)
- beat_tail_en  out  NE  tail-element mask of the beat
- beat_ta  out  1  latched vta
- beat_ma  out  1  latched vma
- beat_last  out  1  final beat of the instruction
- busy  out  1  state != IDLE
- seq_done  out  1  one-cycle completion pulse

Behaviour:
- Reset (n_rst=0 sampled at posedge clk, synchronous): state=IDLE; all outputs 0 except cfg_ready=1; all latched fields cleared.
- Reset takes priority over flush and all other events. A reset mid-instruction drops it with no seq_done.
- FSM states: IDLE, ISSUE, DONE.
- cfg_ready = (state==IDLE).
- IDLE, on cfg_valid&cfg_ready at edge T, latch:
  - evl = min(vec_length, vlmax); comparison is XLEN wide, result is 10 bits.
  - vs = start_element.
  - EPB = DLEN/sew. sew values other than 8/16/32/64 are treated as 32.
  - EPR = VLEN/sew.
  - vta, vma.
  - cur = floor(vs/EPB)*EPB.
- Next state from IDLE: ISSUE if vs < evl, else DONE. In both cases the state takes effect at T+1.
- ISSUE outputs:
  - beat_valid = 1.
  - beat_elem_idx = cur.
  - beat_reg_off = cur / EPR. This is always < vlmul.
  - beat_elem_en[k] = (k<EPB) & (cur+k >= vs) & (cur+k < evl).
  - beat_tail_en[k] = (k<EPB) & (cur+k >= evl).
  - Bits k >= EPB of both masks are 0.
  - beat_last = (cur+EPB >= evl).
- On beat_valid&beat_ready:
  - if beat_last, go to DONE;
  - else cur += EPB.
- Without beat_ready, every beat_* output holds stable.
- Tail-only beats are never issued. The tail appears only in the last beat.
- DONE: seq_done = 1 for exactly one cycle, then IDLE (cfg_ready=1 the following cycle).
- Latency:
  - first beat_valid one cycle after cfg acceptance;
  - seq_done one cycle after the last handshake;
  - seq_done one cycle after acceptance when vs >= evl or evl = 0.
- flush (in ISSUE or DONE): next state IDLE; seq_done and beat_valid suppressed from the next cycle. A flush asserted in IDLE is ignored, and a cfg handshake in the same cycle is still accepted.
- All outputs are registered or decoded from registered state only. There is no combinational path from beat_ready to beat_valid.
- Config inputs are sampled only at acceptance. Changes to the CSR outputs mid-instruction have no effect.

Test Plan:
- Basic SEW=32 walk. Config: sew=32, vlmul=1, vlmax=16, vl=16, vs=0, beat_ready=1. Required: 4 beats with idx 0/4/8/12; en=0x000F; tail=0; reg_off=0; last on idx 12; seq_done the next cycle.
- Prestart and tail. Config: sew=8, vlmax=64, vl=20, vs=5. Required:
  - beat idx 0: en=0xFFE0, last=0;
  - beat idx 16: en=0x000F, tail=0xFFF0, last=1.
- vl clamped by vlmax. Config: sew=32, vlmul=2, vlmax=32, vl=100. Required: 8 beats; reg_off=0 for idx 0..12 and reg_off=1 for idx 16..28; no beat beyond idx 28.
- Empty range. Config: vs=10, vl=8. Required: cfg accepted; beat_valid never asserted; seq_done at T+1; cfg_ready at T+2.
- Backpressure. beat_ready low for 3 cycles on beat idx 4 (SEW=32). Required: idx, en, tail and reg_off are held constant; the beat advances only on the handshake cycle.
- Abort cases:
  - flush during the 2nd beat: state returns to IDLE and no seq_done;
  - n_rst low mid-ISSUE: all outputs are zero and cfg_ready=1 on the next edge;
  - a new config after either abort sequences correctly from its own vs.

Source files
------------

// File: rtl/vec_elem_sequencer.sv
// ---------------------------------------------------------------------------
// vec_elem_sequencer
//
// Purpose:
//   Takes the vector configuration presented by the CSR register file (vl,
//   vstart, SEW, LMUL, VLMAX, vta, vma) and, for each accepted instruction,
//   walks the active element range [vstart, min(vl, vlmax)) in beats one
//   datapath width wide. Every beat reports its first element index, the
//   register offset inside the LMUL group, and per-element enable and tail
//   masks. Beats go to the lane/execute stage over a valid/ready handshake.
//   A one-cycle done pulse tells the control unit the instruction is finished.
//
// Ports:
//   clk, n_rst           clock, synchronous active-low reset
//   cfg_valid/cfg_ready  config handshake (ready only while idle)
//   vec_length           vl
//   start_element        vstart
//   sew                  decoded SEW (8/16/32/64; anything else acts as 32)
//   vlmul                decoded LMUL (informational only)
//   vlmax                VLMAX
//   tail_agnostic        vta, latched at acceptance
//   mask_agnostic        vma, latched at acceptance
//   flush                abort the instruction in flight
//   beat_valid/ready     beat handshake toward the lanes
//   beat_elem_idx        index of the first element of the beat
//   beat_reg_off         register offset within the LMUL group
//   beat_elem_en         active-element mask (bit k = element idx+k)
//   beat_tail_en         tail-element mask
//   beat_ta, beat_ma     latched vta / vma
//   beat_last            final beat of the instruction
//   busy                 sequencer is not idle
//   seq_done             one-cycle completion pulse
// ---------------------------------------------------------------------------
module vec_elem_sequencer #(
    parameter int XLEN = 32,
    parameter int VLEN = 512,
    parameter int DLEN = 128
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [XLEN-1:0]   vec_length,
    input  logic [XLEN-1:0]   start_element,
    input  logic [6:0]        sew,
    input  logic [4:0]        vlmul,
    input  logic [9:0]        vlmax,
    input  logic              tail_agnostic,
    input  logic              mask_agnostic,
    input  logic              flush,
    output logic              beat_valid,
    input  logic              beat_ready,
    output logic [9:0]        beat_elem_idx,
    output logic [2:0]        beat_reg_off,
    output logic [DLEN/8-1:0] beat_elem_en,
    output logic [DLEN/8-1:0] beat_tail_en,
    output logic              beat_ta,
    output logic              beat_ma,
    output logic              beat_last,
    output logic              busy,
    output logic              seq_done
);

    localparam int NE = DLEN / 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DONE
    } SeqStateT;

    SeqStateT    r_state;
    logic [9:0]  r_evl;
    logic [9:0]  r_vs;
    logic [9:0]  r_cur;
    logic [1:0]  r_sewCode;
    logic        r_ta;
    logic        r_ma;

    logic [1:0]  w_cfgSewCode;
    logic [10:0] w_cfgEpb;
    logic [9:0]  w_cfgEvl;
    logic [9:0]  w_cfgCur;
    logic        w_cfgHasWork;
    logic [10:0] w_epb;
    logic [9:0]  w_regOffFull;
    logic        w_lastBeat;
    logic        w_unused;

    // Elements per beat for an encoded SEW (0:8, 1:16, 2:32, 3:64).
    function automatic logic [10:0] epbOf(input logic [1:0] code);
        case (code)
            2'd0:    epbOf = 11'(DLEN / 8);
            2'd1:    epbOf = 11'(DLEN / 16);
            2'd2:    epbOf = 11'(DLEN / 32);
            default: epbOf = 11'(DLEN / 64);
        endcase
    endfunction

    // Which register of the LMUL group an element index lives in. The
    // divisors are elements per register, so these reduce to shifts.
    function automatic logic [9:0] regGroupOf(input logic [9:0] idx,
                                              input logic [1:0] code);
        case (code)
            2'd0:    regGroupOf = idx / 10'(VLEN / 8);
            2'd1:    regGroupOf = idx / 10'(VLEN / 16);
            2'd2:    regGroupOf = idx / 10'(VLEN / 32);
            default: regGroupOf = idx / 10'(VLEN / 64);
        endcase
    endfunction

    // Decode the incoming config so it can be latched in one step when the
    // handshake fires. The effective vl is clamped to VLMAX at full XLEN
    // width before narrowing. The start beat is vstart rounded down to a beat
    // boundary. Beat sizes are powers of two, so masking the low bits is the
    // same as floor division.
    always_comb begin
        w_cfgSewCode = 2'd2;
        case (sew)
            7'd8:    w_cfgSewCode = 2'd0;
            7'd16:   w_cfgSewCode = 2'd1;
            7'd32:   w_cfgSewCode = 2'd2;
            7'd64:   w_cfgSewCode = 2'd3;
            default: w_cfgSewCode = 2'd2;
        endcase
        w_cfgEpb     = epbOf(w_cfgSewCode);
        w_cfgEvl     = (vec_length < XLEN'(vlmax)) ? vec_length[9:0] : vlmax;
        w_cfgHasWork = (start_element < XLEN'(w_cfgEvl));
        w_cfgCur     = start_element[9:0] & ~(w_cfgEpb[9:0] - 10'd1);
    end

    // Quantities derived from the latched state of the instruction in flight.
    // The last beat is the one whose end reaches or passes the effective vl.
    // That guarantees tail-only beats are never issued.
    assign w_epb        = epbOf(r_sewCode);
    assign w_regOffFull = regGroupOf(r_cur, r_sewCode);
    assign w_lastBeat   = (({1'b0, r_cur} + w_epb) >= {1'b0, r_evl});

    // LMUL needs no handling because the walk already stops at min(vl, vlmax).
    // The high offset bits are always zero because offset < LMUL <= 8.
    assign w_unused = ^{vlmul, w_regOffFull[9:3], w_cfgEpb[10]};

    // Main sequencing FSM. Reset beats every other event. Flush only matters
    // once an instruction is in flight, so a flush seen while idle does not
    // block a config accepted in that same cycle. In ISSUE beat_valid is
    // always high, so a handshake is simply beat_ready.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state   <= IDLE;
            r_evl     <= '0;
            r_vs      <= '0;
            r_cur     <= '0;
            r_sewCode <= '0;
            r_ta      <= 1'b0;
            r_ma      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cfg_valid) begin
                        r_evl     <= w_cfgEvl;
                        r_vs      <= start_element[9:0];
                        r_cur     <= w_cfgCur;
                        r_sewCode <= w_cfgSewCode;
                        r_ta      <= tail_agnostic;
                        r_ma      <= mask_agnostic;
                        r_state   <= w_cfgHasWork ? ISSUE : DONE;
                    end
                end
                ISSUE: begin
                    if (flush) begin
                        r_state <= IDLE;
                    end else if (beat_ready) begin
                        if (w_lastBeat) begin
                            r_state <= DONE;
                        end else begin
                            r_cur <= r_cur + w_epb[9:0];
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Outputs decoded purely from registered state. Every beat field is
    // forced to zero outside ISSUE, so reset and idle show clean zeros.
    // Nothing here depends on beat_ready, so fields hold stable under
    // backpressure. Mask bits beyond the current beat size stay zero.
    always_comb begin
        cfg_ready     = (r_state == IDLE);
        busy          = (r_state != IDLE);
        seq_done      = (r_state == DONE);
        beat_valid    = 1'b0;
        beat_elem_idx = '0;
        beat_reg_off  = '0;
        beat_elem_en  = '0;
        beat_tail_en  = '0;
        beat_ta       = 1'b0;
        beat_ma       = 1'b0;
        beat_last     = 1'b0;
        if (r_state == ISSUE) begin
            beat_valid    = 1'b1;
            beat_elem_idx = r_cur;
            beat_reg_off  = w_regOffFull[2:0];
            beat_ta       = r_ta;
            beat_ma       = r_ma;
            beat_last     = w_lastBeat;
            for (int k = 0; k < NE; k++) begin
                beat_elem_en[k] = (11'(k) < w_epb)
                                  && (({1'b0, r_cur} + 11'(k)) >= {1'b0, r_vs})
                                  && (({1'b0, r_cur} + 11'(k)) <  {1'b0, r_evl});
                beat_tail_en[k] = (11'(k) < w_epb)
                                  && (({1'b0, r_cur} + 11'(k)) >= {1'b0, r_evl});
            end
        end
    end

endmodule

// File: tb/tb_vec_elem_sequencer.sv
// ---------------------------------------------------------------------------
// tb_vec_elem_sequencer
//
// Directed bench for vec_elem_sequencer. It drives inputs and samples outputs
// on the falling clock edge. Every expected value below is worked out by hand
// from the configuration applied in that step.
// ---------------------------------------------------------------------------
module tb_vec_elem_sequencer;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] vec_length;
    logic [31:0] start_element;
    logic [6:0]  sew;
    logic [4:0]  vlmul;
    logic [9:0]  vlmax;
    logic        tail_agnostic;
    logic        mask_agnostic;
    logic        flush;
    logic        beat_valid;
    logic        beat_ready;
    logic [9:0]  beat_elem_idx;
    logic [2:0]  beat_reg_off;
    logic [15:0] beat_elem_en;
    logic [15:0] beat_tail_en;
    logic        beat_ta;
    logic        beat_ma;
    logic        beat_last;
    logic        busy;
    logic        seq_done;

    int testCount = 0;
    int failCount = 0;

    vec_elem_sequencer #(
        .XLEN(32),
        .VLEN(512),
        .DLEN(128)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .vec_length    (vec_length),
        .start_element (start_element),
        .sew           (sew),
        .vlmul         (vlmul),
        .vlmax         (vlmax),
        .tail_agnostic (tail_agnostic),
        .mask_agnostic (mask_agnostic),
        .flush         (flush),
        .beat_valid    (beat_valid),
        .beat_ready    (beat_ready),
        .beat_elem_idx (beat_elem_idx),
        .beat_reg_off  (beat_reg_off),
        .beat_elem_en  (beat_elem_en),
        .beat_tail_en  (beat_tail_en),
        .beat_ta       (beat_ta),
        .beat_ma       (beat_ma),
        .beat_last     (beat_last),
        .busy          (busy),
        .seq_done      (seq_done)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Single comparison point: counts it and reports any difference.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Present a config for one edge, then scramble the config inputs so that
    // any resampling after acceptance would show up in later beats.
    task automatic applyStimulus(input logic [31:0] vl, input logic [31:0] vs,
                                 input logic [6:0] sewV, input logic [4:0] lmul,
                                 input logic [9:0] vmax, input logic ta,
                                 input logic ma);
        checkOutput("cfg_ready_pre", 32'(cfg_ready), 32'd1);
        cfg_valid     = 1'b1;
        vec_length    = vl;
        start_element = vs;
        sew           = sewV;
        vlmul         = lmul;
        vlmax         = vmax;
        tail_agnostic = ta;
        mask_agnostic = ma;
        tick();
        cfg_valid     = 1'b0;
        vec_length    = 32'd0;
        start_element = 32'h3FF;
        sew           = 7'd8;
        vlmul         = 5'd8;
        vlmax         = 10'd1;
        tail_agnostic = ~ta;
        mask_agnostic = ~ma;
    endtask

    task automatic checkBeat(input string tag, input logic [9:0] idx,
                             input logic [2:0] off, input logic [15:0] en,
                             input logic [15:0] tail, input logic last);
        checkOutput({tag, "_valid"}, 32'(beat_valid), 32'd1);
        checkOutput({tag, "_idx"}, 32'(beat_elem_idx), 32'(idx));
        checkOutput({tag, "_regoff"}, 32'(beat_reg_off), 32'(off));
        checkOutput({tag, "_en"}, 32'(beat_elem_en), 32'(en));
        checkOutput({tag, "_tail"}, 32'(beat_tail_en), 32'(tail));
        checkOutput({tag, "_last"}, 32'(beat_last), 32'(last));
        checkOutput({tag, "_done"}, 32'(seq_done), 32'd0);
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_cfg_ready"}, 32'(cfg_ready), 32'd1);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_valid"}, 32'(beat_valid), 32'd0);
        checkOutput({tag, "_done"}, 32'(seq_done), 32'd0);
        checkOutput({tag, "_idx"}, 32'(beat_elem_idx), 32'd0);
        checkOutput({tag, "_regoff"}, 32'(beat_reg_off), 32'd0);
        checkOutput({tag, "_en"}, 32'(beat_elem_en), 32'd0);
        checkOutput({tag, "_tail"}, 32'(beat_tail_en), 32'd0);
        checkOutput({tag, "_last"}, 32'(beat_last), 32'd0);
        checkOutput({tag, "_ta"}, 32'(beat_ta), 32'd0);
        checkOutput({tag, "_ma"}, 32'(beat_ma), 32'd0);
    endtask

    task automatic checkDone(input string tag);
        checkOutput({tag, "_done"}, 32'(seq_done), 32'd1);
        checkOutput({tag, "_valid"}, 32'(beat_valid), 32'd0);
        checkOutput({tag, "_cfg_ready"}, 32'(cfg_ready), 32'd0);
    endtask

    // Directed sequence: reset, normal walks, clamping, empty range,
    // backpressure, flush, and reset aborts.
    initial begin
        n_rst         = 1'b0;
        cfg_valid     = 1'b0;
        vec_length    = 32'd0;
        start_element = 32'd0;
        sew           = 7'd32;
        vlmul         = 5'd1;
        vlmax         = 10'd0;
        tail_agnostic = 1'b0;
        mask_agnostic = 1'b0;
        flush         = 1'b0;
        beat_ready    = 1'b1;
        tick();
        tick();
        checkIdle("reset");
        n_rst = 1'b1;
        tick();

        // SEW=32, vl=16: four full beats of 4 elements each.
        applyStimulus(32'd16, 32'd0, 7'd32, 5'd1, 10'd16, 1'b0, 1'b0);
        for (int b = 0; b < 4; b++) begin
            checkBeat("t1_beat", 10'(b * 4), 3'd0, 16'h000F, 16'h0000, (b == 3));
            tick();
        end
        checkDone("t1");
        tick();
        checkIdle("t1_after");

        // SEW=8, vl=20, vstart=5: prestart bits in beat 0, tail in beat 1.
        applyStimulus(32'd20, 32'd5, 7'd8, 5'd1, 10'd64, 1'b1, 1'b1);
        checkBeat("t2_b0", 10'd0, 3'd0, 16'hFFE0, 16'h0000, 1'b0);
        checkOutput("t2_ta", 32'(beat_ta), 32'd1);
        checkOutput("t2_ma", 32'(beat_ma), 32'd1);
        tick();
        checkBeat("t2_b1", 10'd16, 3'd0, 16'h000F, 16'hFFF0, 1'b1);
        tick();
        checkDone("t2");
        tick();

        // vl=100 clamped to vlmax=32, LMUL=2: second register from idx 16.
        applyStimulus(32'd100, 32'd0, 7'd32, 5'd2, 10'd32, 1'b0, 1'b0);
        for (int b = 0; b < 8; b++) begin
            checkBeat("t3_beat", 10'(b * 4), 3'(b / 4), 16'h000F, 16'h0000, (b == 7));
            tick();
        end
        checkDone("t3");
        tick();

        // vstart >= vl: no beats, done straight away, then ready again.
        applyStimulus(32'd8, 32'd10, 7'd32, 5'd1, 10'd16, 1'b0, 1'b0);
        checkDone("t4");
        tick();
        checkIdle("t4_after");

        // Backpressure on the idx-4 beat for three cycles.
        applyStimulus(32'd16, 32'd0, 7'd32, 5'd1, 10'd16, 1'b0, 1'b0);
        checkBeat("t5_b0", 10'd0, 3'd0, 16'h000F, 16'h0000, 1'b0);
        tick();
        checkBeat("t5_b1", 10'd4, 3'd0, 16'h000F, 16'h0000, 1'b0);
        beat_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkBeat("t5_hold", 10'd4, 3'd0, 16'h000F, 16'h0000, 1'b0);
        end
        beat_ready = 1'b1;
        tick();
        checkBeat("t5_b2", 10'd8, 3'd0, 16'h000F, 16'h0000, 1'b0);
        tick();
        checkBeat("t5_b3", 10'd12, 3'd0, 16'h000F, 16'h0000, 1'b1);
        tick();
        checkDone("t5");
        tick();

        // Flush during the second beat: straight back to idle, no done.
        applyStimulus(32'd16, 32'd0, 7'd32, 5'd1, 10'd16, 1'b0, 1'b0);
        checkBeat("t6_b0", 10'd0, 3'd0, 16'h000F, 16'h0000, 1'b0);
        tick();
        checkBeat("t6_b1", 10'd4, 3'd0, 16'h000F, 16'h0000, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkIdle("t6_flushed");
        tick();
        checkIdle("t6_flushed2");

        // Flush held while idle must not block this config: SEW=16, vs=6, vl=12.
        flush = 1'b1;
        applyStimulus(32'd12, 32'd6, 7'd16, 5'd1, 10'd32, 1'b0, 1'b1);
        flush = 1'b0;
        checkBeat("t6n_b0", 10'd0, 3'd0, 16'h00C0, 16'h0000, 1'b0);
        checkOutput("t6n_ma", 32'(beat_ma), 32'd1);
        checkOutput("t6n_ta", 32'(beat_ta), 32'd0);
        tick();
        checkBeat("t6n_b1", 10'd8, 3'd0, 16'h000F, 16'h00F0, 1'b1);
        tick();
        checkDone("t6n");
        tick();

        // Reset in the middle of an instruction.
        applyStimulus(32'd16, 32'd0, 7'd32, 5'd1, 10'd16, 1'b1, 1'b1);
        checkBeat("t7_b0", 10'd0, 3'd0, 16'h000F, 16'h0000, 1'b0);
        tick();
        checkBeat("t7_b1", 10'd4, 3'd0, 16'h000F, 16'h0000, 1'b0);
        n_rst = 1'b0;
        tick();
        n_rst = 1'b1;
        checkIdle("t7_reset");
        tick();
        checkIdle("t7_reset2");

        // SEW=64, vs=7, vl=12: starts on beat idx 6, moves to reg 1 at idx 8.
        applyStimulus(32'd12, 32'd7, 7'd64, 5'd2, 10'd16, 1'b0, 1'b0);
        checkBeat("t7n_b0", 10'd6, 3'd0, 16'h0002, 16'h0000, 1'b0);
        tick();
        checkBeat("t7n_b1", 10'd8, 3'd1, 16'h0003, 16'h0000, 1'b0);
        tick();
        checkBeat("t7n_b2", 10'd10, 3'd1, 16'h0003, 16'h0000, 1'b1);
        tick();
        checkDone("t7n");
        tick();

        // An unrecognised SEW encoding behaves as SEW=32.
        applyStimulus(32'd4, 32'd0, 7'd5, 5'd1, 10'd16, 1'b0, 1'b0);
        checkBeat("t8_b0", 10'd0, 3'd0, 16'h000F, 16'h0000, 1'b1);
        tick();
        checkDone("t8");
        tick();
        checkIdle("t8_after");

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
